secure_lsu: RTL and testbench

- Load/store front-end that sits directly upstream of the secured 1024x32 data memory.
- Accepts one byte, halfword or word request from the core over a valid/ready handshake.
- Checks the request's access key against the memory's key_access output, plus range and alignment, before any memory enable is raised.
- Uses the memory's single-cycle registered read port for loads, and a read-modify-write sequence for sub-word stores because the memory only takes 32-bit writes.

---
 rtl/secure_lsu_pkg.sv | 22 ++
 rtl/secure_lsu_lane.sv | 41 ++++
 rtl/secure_lsu.sv | 167 ++++++++++++++++
 tb/tb_secure_lsu.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_lsu_pkg.sv
// Shared types for the secured load/store unit.
// Size codes, fault codes and the sequencing state enum.
package secure_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] FLT_OK    = 2'd0;
    localparam logic [1:0] FLT_KEY   = 2'd1;
    localparam logic [1:0] FLT_RANGE = 2'd2;
    localparam logic [1:0] FLT_ALIGN = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        RESP
    } state_e;

endpackage

// File: rtl/secure_lsu_lane.sv
// Byte-lane logic: load extract/extend and sub-word store merge.
// Ports: size/uns/off select the lane, word is the memory word,
//   wdata the right-aligned store data; ld_data/st_data are results.
module lsu_lane
    import secure_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];

        ld_data = word;
        st_data = word;
        unique case (size)
            SZ_B: begin
                ld_data = {{24{~uns & byte_sel[7]}}, byte_sel};
                st_data[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ld_data = {{16{~uns & half_sel[15]}}, half_sel};
                st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ld_data = word;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/secure_lsu.sv
// Secured load/store front-end for a 2**ADDR_W x 32 keyed memory.
// Ports: req_* core request, rsp_* response, fault_count,
//   mem_* to/from the memory (registered read, 32-bit writes).
module secure_lsu
    import secure_lsu_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int          KEY_W     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [KEY_W-1:0]  req_key,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_fault,
    output logic [FCNT_W-1:0] fault_count,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_renable,
    input  logic [31:0]       mem_data_out,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [31:0]       mem_data_in,
    output logic              mem_wenable,
    input  logic [KEY_W-1:0]  mem_key_access
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          fault_q, fault_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic [1:0]          flt;
    logic [31:0]         ld_data;
    logic [31:0]         st_data;

    lsu_lane u_lane (
        .size    (size_q),
        .uns     (uns_q),
        .off     (addr_q[1:0]),
        .word    (mem_data_out),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_data (st_data)
    );

    // Checks look at the live request; they only matter on accept.
    always_comb begin
        flt = FLT_OK;
        if (req_key != mem_key_access) begin
            flt = FLT_KEY;
        end else if (req_addr[31:ADDR_W+2]
                     != BASE_ADDR[31:ADDR_W+2]) begin
            flt = FLT_RANGE;
        end else if ((req_size == 2'd3)
                     || (req_size == SZ_H && req_addr[0])
                     || (req_size == SZ_W && req_addr[1:0] != 2'b00)) begin
            flt = FLT_ALIGN;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        fcnt_d    = fcnt_q;
        wr_data_d = wr_data_q;
        req_ready = (state_q == IDLE);
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    fault_d = flt;
                    if (flt != FLT_OK) begin
                        state_d = RESP;
                        if (fcnt_q != '1) begin
                            fcnt_d = fcnt_q + 1'b1;
                        end
                    end else if (req_we && req_size == SZ_W) begin
                        wr_data_d = req_wdata;
                        state_d   = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: state_d = RDW;
            RDW: begin
                if (we_q) begin
                    wr_data_d = st_data;
                    state_d   = WR;
                end else begin
                    rdata_d = ld_data;
                    state_d = RESP;
                end
            end
            WR: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= FLT_OK;
            fcnt_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
            fcnt_q    <= fcnt_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rsp_valid         = (state_q == RESP);
    assign rsp_rdata         = rdata_q;
    assign rsp_fault         = fault_q;
    assign fault_count       = fcnt_q;
    assign mem_read_address  = addr_q[ADDR_W+1:2];
    assign mem_write_address = addr_q[ADDR_W+1:2];
    assign mem_renable       = (state_q == RD);
    assign mem_wenable       = (state_q == WR);
    assign mem_data_in       = wr_data_q;

endmodule

// File: tb/tb_secure_lsu.sv
// Directed bench for secure_lsu with a keyed 1024x32 memory model.
// Latency counted from the accept edge, outputs sampled on negedge.
module tb_secure_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] req_key;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;
    logic [7:0]  fault_count;
    logic [9:0]  mem_read_address;
    logic        mem_renable;
    logic [31:0] mem_data_out;
    logic [9:0]  mem_write_address;
    logic [31:0] mem_data_in;
    logic        mem_wenable;
    logic [15:0] mem_key_access;

    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, ren_k, wen_k;
    logic [31:0] r_data, w_data;
    logic [1:0]  r_fault;
    logic [9:0]  w_addr;
    int          wen_seen;

    always #5 clk = ~clk;

    assign mem_key_access = 16'h0032;

    always @(posedge clk) begin
        if (mem_wenable) mem[mem_write_address] <= mem_data_in;
        if (mem_renable) mem_data_out <= mem[mem_read_address];
    end

    secure_lsu dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_key           (req_key),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_rdata         (rsp_rdata),
        .rsp_fault         (rsp_fault),
        .fault_count       (fault_count),
        .mem_read_address  (mem_read_address),
        .mem_renable       (mem_renable),
        .mem_data_out      (mem_data_out),
        .mem_write_address (mem_write_address),
        .mem_data_in       (mem_data_in),
        .mem_wenable       (mem_wenable),
        .mem_key_access    (mem_key_access)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input logic [15:0] key);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        req_key      = key;
    endtask

    // Waits up to 8 cycles after the accept edge for rsp_valid.
    task automatic wait_rsp();
        lat   = 0;
        ren_k = 0;
        wen_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_renable && ren_k == 0) ren_k = k;
            if (mem_wenable && wen_k == 0) begin
                wen_k  = k;
                w_addr = mem_write_address;
                w_data = mem_data_in;
            end
            if (rsp_valid) begin
                lat     = k;
                r_data  = rsp_rdata;
                r_fault = rsp_fault;
                break;
            end
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [15:0] key);
        @(negedge clk);
        drive(we, sz, uns, a, wd, key);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_data_out = 32'h0;
        wen_seen  = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 16'h0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_fcnt", {24'b0, fault_count}, 32'h0);
        chk("rst_en", {30'b0, mem_renable, mem_wenable}, 32'h0);
        chk("rst_wdin", mem_data_in, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store then load
        xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 16'h0032);
        chk("sw_lat", lat, 2);
        chk("sw_flt", {30'b0, r_fault}, 0);
        chk("sw_wenk", wen_k, 1);
        chk("sw_waddr", {22'b0, w_addr}, 4);
        chk("sw_wdata", w_data, 32'hDEADBEEF);
        chk("sw_renk", ren_k, 0);
        chk("sw_rdata", r_data, 0);
        xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 16'h0032);
        chk("lw_lat", lat, 3);
        chk("lw_renk", ren_k, 1);
        chk("lw_data", r_data, 32'hDEADBEEF);

        // byte RMW and lane loads
        xfer(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000005A, 16'h0032);
        chk("sb_lat", lat, 4);
        chk("sb_renk", ren_k, 1);
        chk("sb_wenk", wen_k, 3);
        chk("sb_wdata", w_data, 32'hDE5ABEEF);
        chk("sb_mem", mem[4], 32'hDE5ABEEF);
        xfer(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 16'h0032);
        chk("lb12", r_data, 32'h0000005A);
        xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 16'h0032);
        chk("lb13", r_data, 32'hFFFFFFDE);
        xfer(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 16'h0032);
        chk("lbu13", r_data, 32'h000000DE);
        xfer(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 16'h0032);
        chk("lh12", r_data, 32'hFFFFDE5A);
        xfer(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 16'h0032);
        chk("lhu10", r_data, 32'h0000BEEF);
        xfer(1'b1, 2'd1, 1'b0, 32'h10, 32'hFFFF1234, 16'h0032);
        chk("sh_lat", lat, 4);
        chk("sh_mem", mem[4], 32'hDE5A1234);

        // faults
        xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 16'h0033);
        chk("key_lat", lat, 1);
        chk("key_flt", {30'b0, r_fault}, 1);
        chk("key_en", ren_k + wen_k, 0);
        chk("key_mem", mem[4], 32'hDE5A1234);
        chk("key_fcnt", {24'b0, fault_count}, 1);
        xfer(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 16'h0033);
        chk("key_pri", {30'b0, r_fault}, 1);
        xfer(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 16'h0032);
        chk("rng_flt", {30'b0, r_fault}, 2);
        chk("rng_en", ren_k + wen_k, 0);
        xfer(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 16'h0032);
        chk("aln_h", {30'b0, r_fault}, 3);
        chk("aln_h_en", ren_k + wen_k, 0);
        xfer(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 16'h0032);
        chk("aln_sz3", {30'b0, r_fault}, 3);
        chk("aln_rd", r_data, 0);
        chk("flt_fcnt", {24'b0, fault_count}, 5);

        // back-pressure
        @(negedge clk);
        rsp_ready = 1'b0;
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 16'h0032);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 16'h0032);
        wait_rsp();
        chk("bp_lat", lat, 3);
        chk("bp_data", r_data, 32'hDE5A1234);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, rsp_valid}, 1);
            chk("bp_hold", rsp_rdata, 32'hDE5A1234);
            chk("bp_ready", {31'b0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle", {31'b0, req_ready}, 1);
        chk("bp_nval", {31'b0, rsp_valid}, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp();
        chk("bp2_lat", lat, 3);
        chk("bp2_data", r_data, 32'h0000005A);
        @(posedge clk);
        #1;

        // saturation
        for (int i = 0; i < 260; i++) begin
            xfer(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 16'h0032);
        end
        chk("sat_fcnt", {24'b0, fault_count}, 32'hFF);

        // reset during RDW of a byte store
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h10, 32'h000000AA, 16'h0032);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rr_rd", {31'b0, mem_renable}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rr_wen", {31'b0, mem_wenable}, 0);
        chk("rr_valid", {31'b0, rsp_valid}, 0);
        chk("rr_fcnt", {24'b0, fault_count}, 0);
        chk("rr_din", mem_data_in, 0);
        chk("rr_waddr", {22'b0, mem_write_address}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wenable) wen_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wenable) wen_seen++;
        end
        chk("rr_nowen", wen_seen, 0);
        chk("rr_mem", mem[4], 32'hDE5A1234);
        xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 16'h0032);
        chk("rr_load", r_data, 32'hDE5A1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
